// File: rtl/rgb_led_sched.sv
// rgb_led_sched
// Shares one active-low RGB status LED between NREQ status sources.
// The lowest-index requester wins. A grant is held for at least HOLD_TICKS
// ms-ticks before the sources are re-arbitrated. Colour and blink enable are
// captured when a grant is issued. A blinking owner alternates lit and dark
// every BLINK_TICKS ticks.
//
// Ports:
//   clk    system clock
//   rst    synchronous reset, active-high
//   req    [NREQ]    level request per source
//   color  [3*NREQ]  per-source colour, {B,G,R} per source, 1 = lit
//   blink  [NREQ]    per-source blink enable
//   grant  [NREQ]    one-hot current owner, 0 when idle
//   busy             1 while a grant is active
//   r/g/b            LED pins, active-low
module rgb_led_sched #(
    parameter int NREQ        = 4,
    parameter int TICK_DIV    = 24000,
    parameter int HOLD_TICKS  = 500,
    parameter int BLINK_TICKS = 250
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [3*NREQ-1:0]   color,
    input  logic [NREQ-1:0]     blink,
    output logic [NREQ-1:0]     grant,
    output logic                busy,
    output logic                r,
    output logic                g,
    output logic                b
);

    localparam int TICK_W  = (TICK_DIV > 1)    ? $clog2(TICK_DIV)       : 1;
    // The hold counter must be able to hold HOLD_TICKS itself, not just
    // HOLD_TICKS-1.
    localparam int HOLD_W  = (HOLD_TICKS > 0)  ? $clog2(HOLD_TICKS + 1) : 1;
    localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS)    : 1;

    typedef enum logic {S_IDLE, S_SHOW} state_t;

    state_t               r_state;
    logic [NREQ-1:0]      r_grant;
    logic [2:0]           r_lc;
    logic                 r_lb;
    logic                 r_phase;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic [HOLD_W-1:0]    r_hold;
    logic [BLINK_W-1:0]   r_blink_cnt;

    logic                 w_any;
    logic [NREQ-1:0]      w_win_onehot;
    logic [2:0]           w_win_color;
    logic                 w_win_blink;
    logic                 w_tick;
    logic                 w_hold_done;
    logic                 w_load;
    logic                 w_to_idle;
    logic                 w_on;

    // Fixed-priority select. Scanning from the top down lets the lowest
    // index overwrite the others.
    // NOTE: every always_comb output gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_any        = 1'b0;
        w_win_onehot = '0;
        w_win_color  = 3'b000;
        w_win_blink  = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_any           = 1'b1;
                w_win_onehot    = '0;
                w_win_onehot[i] = 1'b1;
                w_win_color     = color[3*i +: 3];
                w_win_blink     = blink[i];
            end
        end
    end

    assign w_tick      = (r_tick_cnt == TICK_W'(TICK_DIV - 1));
    assign w_hold_done = (r_hold == '0);

    // A fresh grant comes either from idle or from a different winner once
    // the hold has expired. If the same owner is still winning, the grant
    // is kept without reloading.
    assign w_load    = w_any && ((r_state == S_IDLE) ||
                                 (w_hold_done && (w_win_onehot != r_grant)));
    assign w_to_idle = (r_state == S_SHOW) && w_hold_done && !w_any;

    // NOTE: all state is updated with non-blocking assignments so that every
    // register samples pre-edge values. Later assignments in the block win.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_lc        <= 3'b000;
            r_lb        <= 1'b0;
            r_phase     <= 1'b1;
            r_tick_cnt  <= '0;
            r_hold      <= '0;
            r_blink_cnt <= '0;
        end else if (w_load) begin
            r_state     <= S_SHOW;
            r_grant     <= w_win_onehot;
            r_lc        <= w_win_color;
            r_lb        <= w_win_blink;
            r_phase     <= 1'b1;
            r_tick_cnt  <= '0;
            r_hold      <= HOLD_W'(HOLD_TICKS);
            r_blink_cnt <= '0;
        end else if (w_to_idle) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_phase     <= 1'b1;
            r_tick_cnt  <= '0;
            r_blink_cnt <= '0;
        end else if (r_state == S_SHOW) begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_tick) begin
                if (!w_hold_done) begin
                    r_hold <= r_hold - 1'b1;
                end
                if (r_blink_cnt == BLINK_W'(BLINK_TICKS - 1)) begin
                    r_blink_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    // The outputs are decoded from registers only. Nothing passes straight
    // from an input to an output.
    assign w_on  = !r_lb || r_phase;
    assign grant = r_grant;
    assign busy  = (r_state == S_SHOW);
    assign r     = !(busy && r_lc[0] && w_on);
    assign g     = !(busy && r_lc[1] && w_on);
    assign b     = !(busy && r_lc[2] && w_on);

endmodule

// File: tb/tb_rgb_led_sched.sv
// tb_rgb_led_sched
// Directed bench for rgb_led_sched (TICK_DIV=4, HOLD_TICKS=3, BLINK_TICKS=2).
// A cycle-level model tracks the owner, the cycles elapsed since the grant
// and the latched colour and blink. The outputs are derived from that state
// with plain arithmetic. Hand-computed literals pin the model at key points.
module tb_rgb_led_sched;

    localparam int NREQ        = 4;
    localparam int TICK_DIV    = 4;
    localparam int HOLD_TICKS  = 3;
    localparam int BLINK_TICKS = 2;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [3*NREQ-1:0]   color;
    logic [NREQ-1:0]     blink;
    logic [NREQ-1:0]     grant;
    logic                busy;
    logic                r;
    logic                g;
    logic                b;

    int errors = 0;
    int checks = 0;

    rgb_led_sched #(
        .NREQ        (NREQ),
        .TICK_DIV    (TICK_DIV),
        .HOLD_TICKS  (HOLD_TICKS),
        .BLINK_TICKS (BLINK_TICKS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .color (color),
        .blink (blink),
        .grant (grant),
        .busy  (busy),
        .r     (r),
        .g     (g),
        .b     (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {grant,busy,rgb}=%b required %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner index (-1 = idle) and the number of cycles since the grant
    // became visible.
    int         m_owner = -1;
    int         m_k     = 0;
    logic [2:0] m_lc    = 3'b000;
    logic       m_lb    = 1'b0;

    function automatic logic [7:0] model_out();
        logic [3:0] gnt;
        logic       on;
        logic [2:0] led;
        if (m_owner < 0) return {4'b0000, 1'b0, 3'b111};
        gnt = 4'b0000;
        gnt[m_owner] = 1'b1;
        on  = !m_lb || (((m_k / (BLINK_TICKS * TICK_DIV)) % 2) == 0);
        led = ~(m_lc & {3{on}});
        return {gnt, 1'b1, led[0], led[1], led[2]};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_owner = -1;
                m_k     = 0;
            end else begin
                int win;
                win = -1;
                for (int i = NREQ - 1; i >= 0; i--) if (req[i]) win = i;
                if (m_owner < 0 || m_k >= HOLD_TICKS * TICK_DIV) begin
                    if (win < 0) begin
                        m_owner = -1;
                    end else if (win != m_owner) begin
                        m_owner = win;
                        m_k     = 0;
                        m_lc    = color[3*win +: 3];
                        m_lb    = blink[win];
                    end else begin
                        m_k++;
                    end
                end else begin
                    m_k++;
                end
            end
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("model", {grant, busy, r, g, b}, model_out());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    localparam logic [7:0] IDLE_O = {4'b0000, 1'b0, 3'b111};

    initial begin
        rst   = 1'b1;
        req   = 4'b1111;
        color = 12'b111_101_010_010;
        blink = 4'b0000;

        // 1: reset with all requests active, then the first grant.
        adv(2);
        check("t1_reset", {grant, busy, r, g, b}, IDLE_O);
        rst = 1'b0;
        adv(1);
        check("t1_first_grant", {grant, busy, r, g, b}, {4'b0001, 1'b1, 3'b101});
        req = 4'b0000;
        adv(15);
        check("t1_idle", {grant, busy, r, g, b}, IDLE_O);

        // 2: owner 2 shows magenta (R+B).
        req = 4'b0100;
        adv(1);
        check("t2_k0", {grant, busy, r, g, b}, {4'b0100, 1'b1, 3'b010});
        adv(1);
        check("t2_k1", {grant, busy, r, g, b}, {4'b0100, 1'b1, 3'b010});

        // 3: source 0 rises at k=2 and preempts only at k=13.
        adv(1);
        req = 4'b0101;
        adv(10);
        check("t3_k12_held", {grant, busy, r, g, b}, {4'b0100, 1'b1, 3'b010});
        adv(1);
        check("t3_k13_preempt", {grant, busy, r, g, b}, {4'b0001, 1'b1, 3'b101});
        req = 4'b0000;
        adv(15);

        // 4: source 1 blinks green with a phase of 8 cycles.
        req   = 4'b0010;
        blink = 4'b0010;
        adv(1);
        check("t4_k0_on", {grant, busy, r, g, b}, {4'b0010, 1'b1, 3'b101});
        adv(7);
        check("t4_k7_on", {grant, busy, r, g, b}, {4'b0010, 1'b1, 3'b101});
        adv(1);
        check("t4_k8_off", {grant, busy, r, g, b}, {4'b0010, 1'b1, 3'b111});
        adv(7);
        check("t4_k15_off", {grant, busy, r, g, b}, {4'b0010, 1'b1, 3'b111});
        adv(1);
        check("t4_k16_on", {grant, busy, r, g, b}, {4'b0010, 1'b1, 3'b101});
        adv(7);
        check("t4_k23_on", {grant, busy, r, g, b}, {4'b0010, 1'b1, 3'b101});
        req   = 4'b0000;
        blink = 4'b0000;
        adv(15);

        // 5a: owner 3 drops at k=1. The display is held, then goes idle at k=13.
        req = 4'b1000;
        adv(1);
        check("t5a_k0", {grant, busy, r, g, b}, {4'b1000, 1'b1, 3'b000});
        adv(1);
        req = 4'b0000;
        adv(11);
        check("t5a_k12_held", {grant, busy, r, g, b}, {4'b1000, 1'b1, 3'b000});
        adv(1);
        check("t5a_k13_idle", {grant, busy, r, g, b}, IDLE_O);

        // 5b: owner 3 drops and source 2 rises at k=5. Handover is direct.
        req = 4'b1000;
        adv(1);
        adv(1);
        req = 4'b0000;
        adv(4);
        req = 4'b0100;
        adv(7);
        check("t5b_k12_held", {grant, busy, r, g, b}, {4'b1000, 1'b1, 3'b000});
        adv(1);
        check("t5b_k13_handover", {grant, busy, r, g, b}, {4'b0100, 1'b1, 3'b010});
        req = 4'b0000;
        adv(15);

        // 6: reset pulse in the middle of a blinking show, then a regrant.
        req   = 4'b0010;
        blink = 4'b0010;
        adv(1);
        adv(6);
        rst = 1'b1;
        adv(1);
        check("t6_reset", {grant, busy, r, g, b}, IDLE_O);
        rst = 1'b0;
        adv(1);
        check("t6_regrant", {grant, busy, r, g, b}, {4'b0010, 1'b1, 3'b101});
        adv(7);
        check("t6_k7_on", {grant, busy, r, g, b}, {4'b0010, 1'b1, 3'b101});
        adv(1);
        check("t6_k8_off", {grant, busy, r, g, b}, {4'b0010, 1'b1, 3'b111});
        req   = 4'b0000;
        blink = 4'b0000;
        adv(15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
